// File: rtl/mini_core_accel_mul_int8_pkg.sv
// Shared types and constants for the sequential int8 Booth multiplier slot.
package mini_core_accel_mul_int8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } t_mul_int8_state;

  localparam int MUL_INT8_DATA_W  = 8;
  localparam int MUL_INT8_LATENCY = 9;

endpackage

// File: rtl/mini_core_accel_mul_int8_if.sv
// CR-to-farm link for one multiplier slot: level-held operands in, {done, result, busy} back.
interface mini_core_accel_mul_int8_if
  import mini_core_accel_mul_int8_pkg::*;
#(
  parameter int DATA_W = MUL_INT8_DATA_W,
  parameter int RES_W  = 2 * MUL_INT8_DATA_W
);

  logic signed [DATA_W-1:0] multiplicand;
  logic signed [DATA_W-1:0] multiplier;
  logic signed [RES_W-1:0]  result;
  logic                     done;
  logic                     busy;

  modport master (
    output multiplicand, multiplier,
    input  result, done, busy
  );

  modport slave (
    input  multiplicand, multiplier,
    output result, done, busy
  );

endinterface

// File: rtl/mini_core_accel_mul_int8_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of A into the upper field, then ASR by 1.
module mini_core_accel_booth_step #(
  parameter int DATA_W = 8
) (
  input  logic signed [2*DATA_W+1:0] p_i,
  input  logic signed [DATA_W:0]     a_i,
  output logic signed [2*DATA_W+1:0] p_o
);

  logic signed [DATA_W:0] upper;
  logic signed [DATA_W:0] sum;

  always_comb begin
    upper = p_i[2*DATA_W+1 -: DATA_W+1];
    sum   = upper;
    unique case (p_i[1:0])
      2'b01:   sum = upper + a_i;
      2'b10:   sum = upper - a_i;
      default: sum = upper;
    endcase
    // Upper field is one bit wider than A, so subtracting -2^(DATA_W-1) cannot overflow.
    p_o = {sum[DATA_W], sum, p_i[DATA_W:1]};
  end

endmodule

// File: rtl/mini_core_accel_mul_int8.sv
// Farm-side signed int8 multiplier: detects operand changes on the CR link and runs a Booth loop.
module mini_core_accel_mul_int8
  import mini_core_accel_mul_int8_pkg::*;
#(
  parameter int DATA_W = MUL_INT8_DATA_W,
  parameter int RES_W  = 2 * MUL_INT8_DATA_W
) (
  input  logic                        Clk,
  input  logic                        Rst_N,
  mini_core_accel_mul_int8_if.slave   cr
);

  localparam int P_W   = RES_W + 2;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  t_mul_int8_state          state_q, state_d;
  logic signed [RES_W-1:0]  result_q, result_d;
  logic                     done_q, done_d;
  logic signed [DATA_W-1:0] snap_a_q, snap_a_d;
  logic signed [DATA_W-1:0] snap_b_q, snap_b_d;
  logic                     snap_valid_q, snap_valid_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [P_W-1:0]    p_q, p_d;

  logic                     start_req;
  logic signed [DATA_W:0]   a_ext;
  logic signed [P_W-1:0]    p_step;

  assign a_ext = {snap_a_q[DATA_W-1], snap_a_q};

  mini_core_accel_booth_step #(
    .DATA_W (DATA_W)
  ) u_booth_step (
    .p_i (p_q),
    .a_i (a_ext),
    .p_o (p_step)
  );

  // No start strobe on CR: any operand change (or an empty snapshot) triggers a fresh compute.
  assign start_req = !snap_valid_q
                   || (cr.multiplicand != snap_a_q)
                   || (cr.multiplier   != snap_b_q);

  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    done_d       = done_q;
    snap_a_d     = snap_a_q;
    snap_b_d     = snap_b_q;
    snap_valid_d = snap_valid_q;
    cnt_d        = cnt_q;
    p_d          = p_q;

    if (start_req) begin
      // Restart also covers CALC: abandoned operands never produce a done.
      state_d      = CALC;
      done_d       = 1'b0;
      snap_a_d     = cr.multiplicand;
      snap_b_d     = cr.multiplier;
      snap_valid_d = 1'b1;
      cnt_d        = '0;
      p_d          = {{(DATA_W+1){1'b0}}, cr.multiplier, 1'b0};
    end else begin
      unique case (state_q)
        CALC: begin
          p_d   = p_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            result_d = p_step[RES_W:1];
            done_d   = 1'b1;
            state_d  = DONE;
          end
        end
        IDLE, DONE: state_d = state_q;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_N) begin
      state_q      <= IDLE;
      result_q     <= '0;
      done_q       <= 1'b0;
      snap_a_q     <= '0;
      snap_b_q     <= '0;
      snap_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      result_q     <= result_d;
      done_q       <= done_d;
      snap_a_q     <= snap_a_d;
      snap_b_q     <= snap_b_d;
      snap_valid_q <= snap_valid_d;
      cnt_q        <= cnt_d;
    end
    p_q <= p_d;
  end

  assign cr.result = result_q;
  assign cr.done   = done_q;
  assign cr.busy   = (state_q == CALC);

endmodule

// File: tb/tb_mini_core_accel_mul_int8.sv
// Directed and randomized checks of the int8 Booth multiplier slot against a plain-arithmetic model.
module tb_mini_core_accel_mul_int8;
  import mini_core_accel_mul_int8_pkg::*;

  localparam int DW  = MUL_INT8_DATA_W;
  localparam int RW  = 2 * DW;
  localparam int LAT = MUL_INT8_LATENCY;

  logic Clk   = 1'b0;
  logic Rst_N = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] last_res;
  int cur_a, cur_b;

  mini_core_accel_mul_int8_if #(.DATA_W(DW), .RES_W(RW)) cr ();

  mini_core_accel_mul_int8 #(.DATA_W(DW), .RES_W(RW)) dut (
    .Clk   (Clk),
    .Rst_N (Rst_N),
    .cr    (cr)
  );

  always #5 Clk = ~Clk;

  function automatic logic [RW-1:0] ref_mul(input int a, input int b);
    int prod;
    prod = a * b;
    return RW'(prod);
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int a, input int b);
    cur_a = a;
    cur_b = b;
    cr.multiplicand = DW'(a);
    cr.multiplier   = DW'(b);
  endtask

  // Operands must already have changed; the next edge observes the change.
  task automatic expect_product(input string tag, input int a, input int b);
    logic [RW-1:0] exp;
    exp = ref_mul(a, b);
    for (int c = 1; c <= LAT; c++) begin
      tick();
      if (c < LAT) begin
        chk({tag, "_done_low"}, RW'(cr.done), RW'(0));
        chk({tag, "_busy_high"}, RW'(cr.busy), RW'(1));
      end
      if (c == LAT - 1) chk({tag, "_result_hold"}, cr.result, last_res);
    end
    chk({tag, "_done"}, RW'(cr.done), RW'(1));
    chk({tag, "_result"}, cr.result, exp);
    chk({tag, "_busy_low"}, RW'(cr.busy), RW'(0));
    last_res = exp;
  endtask

  int corner_a [5] = '{-128, -128, 127, -1, 0};
  int corner_b [5] = '{-128,  127, 127, -1, -128};

  initial begin
    int a, b, b2, k;

    // Reset state
    drive(0, 0);
    Rst_N = 1'b0;
    repeat (3) tick();
    chk("reset_done", RW'(cr.done), RW'(0));
    chk("reset_busy", RW'(cr.busy), RW'(0));
    chk("reset_result", cr.result, RW'(0));
    last_res = '0;

    // Release with operands 0/0: empty snapshot forces a compute
    Rst_N = 1'b1;
    expect_product("rst_release", 0, 0);

    // 3*5, then hold with no recompute
    drive(3, 5);
    expect_product("mul_3x5", 3, 5);
    repeat (20) begin
      tick();
      chk("hold_done", RW'(cr.done), RW'(1));
      chk("hold_busy", RW'(cr.busy), RW'(0));
      chk("hold_result", cr.result, RW'(16'h000F));
    end

    // Corner products
    for (int i = 0; i < 5; i++) begin
      drive(corner_a[i], corner_b[i]);
      expect_product($sformatf("corner%0d", i), corner_a[i], corner_b[i]);
      repeat (3) tick();
    end
    chk("corner_last_const", cr.result, 16'h0000);

    // Mid-compute change of B abandons 7*9
    drive(7, 9);
    repeat (4) begin
      tick();
      chk("restart_pre_done", RW'(cr.done), RW'(0));
    end
    drive(7, -2);
    expect_product("restart_7x-2", 7, -2);
    chk("restart_const", cr.result, 16'hFFF2);

    // Byte-wise CR stores: A then B one cycle later
    cr.multiplicand = DW'(6);
    cur_a = 6;
    tick();
    chk("bytewise_done_low", RW'(cr.done), RW'(0));
    chk("bytewise_busy", RW'(cr.busy), RW'(1));
    cr.multiplier = DW'(-4);
    cur_b = -4;
    expect_product("bytewise_6x-4", 6, -4);
    chk("bytewise_const", cr.result, 16'hFFE8);
    repeat (5) begin
      tick();
      chk("bytewise_single_done", RW'(cr.done), RW'(1));
    end

    // Reset pulse mid-compute of 10*10
    drive(10, 10);
    repeat (4) tick();
    Rst_N = 1'b0;
    tick();
    chk("midrst_done", RW'(cr.done), RW'(0));
    chk("midrst_result", cr.result, RW'(0));
    chk("midrst_busy", RW'(cr.busy), RW'(0));
    last_res = '0;
    Rst_N = 1'b1;
    expect_product("midrst_10x10", 10, 10);
    chk("midrst_const", cr.result, 16'h0064);

    // Randomized operands, some with a mid-compute change of B
    for (int n = 0; n < 24; n++) begin
      do begin
        a = int'($urandom_range(0, 255)) - 128;
        b = int'($urandom_range(0, 255)) - 128;
      end while (a == cur_a && b == cur_b);
      drive(a, b);
      if ($urandom_range(0, 1) == 1) begin
        k = int'($urandom_range(1, 7));
        repeat (k) begin
          tick();
          chk("rand_pre_done", RW'(cr.done), RW'(0));
        end
        do b2 = int'($urandom_range(0, 255)) - 128; while (b2 == b);
        drive(a, b2);
        expect_product($sformatf("rand_restart%0d", n), a, b2);
      end else begin
        expect_product($sformatf("rand%0d", n), a, b);
      end
      repeat (int'($urandom_range(0, 3))) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mini_core_accel_mul_int8.md
Name: mini_core_accel_mul_int8

Overview:
- Sequential signed int8 multiplier accelerator.
- Sits on the accelerator-farm side of the CR interface as the responder: one instance per farm slot (8 slots).
- Consumes the level-held multiplicand/multiplier driven from the CR block (core2mul_int8[i]) and returns {done, result} (mul2core_int8[i]).
- The CR interface has no start strobe, so the block detects operand changes itself and computes with a radix-2 Booth loop, one step per cycle.

Parameters:
- DATA_W, 8, operand width (signed two's complement).
- RES_W, 16, result width; must equal 2*DATA_W.

Ports:
- Clk  in  1  clock
- Rst_N  in  1  synchronous active-low reset
- multiplicand  in  DATA_W  signed operand A, level-held from CR
- multiplier  in  DATA_W  signed operand B, level-held from CR
- result  out  RES_W  signed product A*B, registered
- done  out  1  result is valid for the current operands
- busy  out  1  Booth loop in progress (state CALC)

Behaviour:
- Reset: synchronous, sampled on the Clk rising edge while Rst_N=0.
  - Sets state=IDLE, result=0, done=0, busy=0, snapshot A/B=0, snap_valid=0, step counter=0.
- Change detect: start_req = !snap_valid | (multiplicand != snapA) | (multiplier != snapB).
  - Evaluated every cycle in all states.
- States: IDLE, CALC, DONE.
- IDLE or DONE with start_req:
  - Capture A/B into the snapshots; set snap_valid=1.
  - Load accumulator: P = {(DATA_W+1) zeros, B, 1'b0}; A is held sign-extended to DATA_W+1 bits.
  - Clear cnt and done; go to CALC.
- IDLE or DONE without start_req: hold all outputs.
- CALC, each cycle, one Booth step:
  - On P[1:0]: 01 adds A to the upper field, 10 subtracts A, 00/11 do nothing.
  - Then arithmetic shift right of P by 1; cnt++.
  - Upper field is DATA_W+1 bits so that subtracting -128 does not overflow.
- CALC with cnt==DATA_W-1:
  - Register result = final P[RES_W:1]; set done=1; go to DONE.
- Latency: operands observed changed in cycle N → done=1 and result valid from cycle N+DATA_W+1 (9 for int8).
- Restart: start_req during CALC (operand change mid-compute):
  - Abort, re-capture, cnt=0, stay in CALC; done stays 0.
  - No done pulse is ever produced for the abandoned operands.
  - The CR writes multiplicand and multiplier in separate stores, so two back-to-back restarts are normal.
- result holds its previous value while done=0. Consumers qualify result with done.
- busy=1 exactly when state==CALC.
- After reset release with operands at 0, snap_valid=0 forces a compute, so done rises with result 0 (no stale-done window).
- Range: full signed range is exact, with no saturation.
  - -128*-128 = 0x4000.
  - -128*127 = 0xC080.
- Reset mid-CALC: next cycle is IDLE, done=0, result=0. Recomputation starts on the first cycle with Rst_N=1.

Decomposition:
- Add to mini_core_accel_pkg:
  - t_mul_int8_state enum {IDLE, CALC, DONE}.
  - Localparams MUL_INT8_DATA_W=8 and MUL_INT8_LATENCY=9.
- Existing t_accel_farm_input / t_accel_farm_output core2mul_int8 / mul2core_int8 fields map directly to the ports; the farm wrapper instantiates 8 copies.
- One natural sub-module: mini_core_accel_booth_step, combinational, inputs P and A, output next P. It is unit-testable in isolation.

Test Plan:
- Reset release, operands 0/0 → done=0 for cycles 1-8 after release, done=1 with result=0x0000 at cycle 9; busy=1 only in cycles 1-8.
- Set A=3, B=5 in the same cycle → done drops next cycle, result=0x000F and done=1 nine cycles after change; hold for 20 cycles → no recompute, busy stays 0.
- Corner products, each with a 12-cycle gap:
  - -128*-128 → 0x4000
  - -128*127 → 0xC080
  - 127*127 → 0x3F01
  - -1*-1 → 0x0001
  - 0*-128 → 0x0000
- Set A=7, B=9, then change B to -2 at CALC cycle 4 → no done for 63; done at 9 cycles after the B change with result 0xFFF2 (-14).
- Write A=6, then B=-4 one cycle later (CR byte-wise stores) → single done pulse with result 0xFFE8, 9 cycles after the B change.
- Drive Rst_N=0 for 1 cycle mid-CALC of 10*10 → next cycle done=0, result=0, busy=0; after release done=1 with result=0x0064 nine cycles later.
